// File: rtl/booth4_div_pkg.sv
// Shared types and sizing helpers for booth4_divider_nbit.
package booth4_div_pkg;

  localparam int DEF_DIV_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    SEND = 2'd3
  } state_t;

  // Counter width for a given operand width.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/brent_kung_adder_nbit.sv
// Brent-Kung parallel-prefix adder. Carry-in is folded into bit 0 so the
// prefix tree covers only the low WIDTH-1 bits that feed a higher sum bit.
module brent_kung_adder_nbit #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             cin,
  output logic [WIDTH-1:0] out_sum
);

  localparam int M   = WIDTH - 1;
  localparam int TOP = 1 << ($clog2(M) - 1);

  logic [WIDTH-1:0] p;
  logic [M-1:0]     gp;
  logic [M-1:0]     pp;

  always_comb begin
    p  = in_op1 ^ in_op2;
    gp = in_op1[M-1:0] & in_op2[M-1:0];
    pp = p[M-1:0];
    gp[0] = gp[0] | (pp[0] & cin);
    for (int d = 1; d < M; d = d * 2) begin
      for (int i = 2 * d - 1; i < M; i += 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    // Down-sweep fills the prefixes the up-sweep skipped.
    for (int d = TOP; d > 0; d = d / 2) begin
      for (int i = 3 * d - 1; i < M; i += 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
      end
    end
    out_sum = p ^ {gp, cin};
  end

endmodule

// File: rtl/booth4_divider_nbit.sv
// Sequential radix-2 restoring divider with valid/ready handshakes.
// BOOTH4_DIV_FAST_SPECIAL_EN: divide-by-zero/overflow results skip CALC/FIX.
//   state | meaning
//   IDLE  | waiting for operands, out_ready high
//   CALC  | one quotient bit per cycle, DIV_SIZE cycles
//   FIX   | sign correction and special-case overrides
//   SEND  | result held until in_ready
module booth4_divider_nbit
  import booth4_div_pkg::*;
#(
  parameter int DIV_SIZE = DEF_DIV_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_SIZE-1:0] in_op1,
  input  logic [DIV_SIZE-1:0] in_op2,
  input  logic                in_op1_signed,
  input  logic                in_op2_signed,
  input  logic                in_valid,
  output logic                out_ready,
  input  logic                in_ready,
  output logic                out_valid,
  output logic [DIV_SIZE-1:0] out_quo,
  output logic [DIV_SIZE-1:0] out_rem
);

  localparam int N     = DIV_SIZE;
  localparam int CNT_W = cnt_w(DIV_SIZE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     rem_q, rem_d, quo_q, quo_d, div_q, div_d, op1_q, op1_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;

  logic             sgn1, sgn2, accept, cap_dz, cap_ovf, fast_special;
  logic [N-1:0]     mag1, mag2;
  logic [N:0]       shifted, trial;

  assign sgn1    = in_op1_signed & in_op1[N-1];
  assign sgn2    = in_op2_signed & in_op2[N-1];
  assign mag1    = sgn1 ? (~in_op1 + 1'b1) : in_op1;
  assign mag2    = sgn2 ? (~in_op2 + 1'b1) : in_op2;
  assign cap_dz  = (in_op2 == '0);
  assign cap_ovf = in_op1_signed & in_op2_signed &
                   (in_op1 == {1'b1, {(N-1){1'b0}}}) & (&in_op2);
  assign accept  = in_valid & out_ready;

`ifdef BOOTH4_DIV_FAST_SPECIAL_EN
  assign fast_special = cap_dz | cap_ovf;
`else
  assign fast_special = 1'b0;
`endif

  // Partial remainder can reach 2*divisor-1, hence the extra bit.
  assign shifted = {rem_q, quo_q[N-1]};

  brent_kung_adder_nbit #(.WIDTH(N + 1)) u_trial (
    .in_op1 (shifted),
    .in_op2 (~{1'b0, div_q}),
    .cin    (1'b1),
    .out_sum(trial)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    op1_d     = op1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_d     = mag2;
          op1_d     = in_op1;
          neg_quo_d = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
          dz_d      = cap_dz;
          ovf_d     = cap_ovf;
          if (fast_special) begin
            state_d = SEND;
            quo_d   = cap_dz ? '1 : in_op1;
            rem_d   = cap_dz ? in_op1 : '0;
          end else begin
            state_d = CALC;
            quo_d   = mag1;
            rem_d   = '0;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        quo_d = {quo_q[N-2:0], ~trial[N]};
        rem_d = trial[N] ? shifted[N-1:0] : trial[N-1:0];
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        quo_d   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_d   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (dz_q) begin
          quo_d = '1;
          rem_d = op1_q;
        end else if (ovf_q) begin
          quo_d = op1_q;
          rem_d = '0;
        end
        state_d = SEND;
      end
      SEND: begin
        if (in_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      op1_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      op1_q     <= op1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_ready = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_quo   = out_valid ? quo_q : '0;
  assign out_rem   = out_valid ? rem_q : '0;

endmodule
